// File: rtl/ccx_emu_unit.sv
// Emulation responder for the CCX custom-instruction port: deserialises two
// chunk-serial operands, computes AND/ADD, and streams the result back at a fixed latency.
module ccx_emu_unit #(
  parameter int unsigned CHUNKSIZE = 4,
  parameter int unsigned RES_DLY   = 10
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 req_i,
  input  logic                 sel_i,
  input  logic [CHUNKSIZE-1:0] rs_a_i,
  input  logic [CHUNKSIZE-1:0] rs_b_i,
  output logic [CHUNKSIZE-1:0] res_o,
  output logic                 resp_o,
  output logic                 busy_o,
  output logic                 err_o
);

  localparam int unsigned NCHUNK = 32 / CHUNKSIZE;
  localparam int unsigned OPW    = 32 - CHUNKSIZE;
  localparam int unsigned CW     = $clog2(RES_DLY + NCHUNK);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_CAPTURE = 2'd1;
  localparam logic [1:0] ST_WAIT    = 2'd2;
  localparam logic [1:0] ST_RESPOND = 2'd3;

  localparam logic [CW-1:0] CNT_LAST_OP   = CW'(NCHUNK - 1);
  localparam logic [CW-1:0] CNT_WAIT_END  = CW'(RES_DLY - 1);
  localparam logic [CW-1:0] CNT_FIRST_RES = CW'(RES_DLY);
  localparam logic [CW-1:0] CNT_LAST_RES  = CW'(RES_DLY + NCHUNK - 1);

  logic [1:0]           state, state_nxt;
  logic [CW-1:0]        cnt, cnt_nxt;
  logic [OPW-1:0]       op_a, op_a_nxt, op_b, op_b_nxt;
  logic                 sel_q, sel_nxt;
  logic [31:0]          result, result_nxt;
  logic [CHUNKSIZE-1:0] res_nxt;
  logic                 resp_nxt, busy_nxt, err_nxt;
  logic [31:0]          full_a_c, full_b_c;
  logic [CW-1:0]        idx_c;

  // Operand registers hold chunks 0..NCHUNK-2; the last chunk joins straight from the port
  assign full_a_c = {rs_a_i, op_a};
  assign full_b_c = {rs_b_i, op_b};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      op_a   <= '0;
      op_b   <= '0;
      sel_q  <= 1'b0;
      result <= '0;
      res_o  <= '0;
      resp_o <= 1'b0;
      busy_o <= 1'b0;
      err_o  <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      op_a   <= op_a_nxt;
      op_b   <= op_b_nxt;
      sel_q  <= sel_nxt;
      result <= result_nxt;
      res_o  <= res_nxt;
      resp_o <= resp_nxt;
      busy_o <= busy_nxt;
      err_o  <= err_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    op_a_nxt   = op_a;
    op_b_nxt   = op_b;
    sel_nxt    = sel_q;
    result_nxt = result;
    res_nxt    = '0;
    resp_nxt   = 1'b0;
    busy_nxt   = 1'b0;
    // Any request outside IDLE is a protocol violation and is otherwise ignored
    err_nxt    = err_o | (req_i & (state != ST_IDLE));

    case (state)
      ST_IDLE: begin
        if (req_i) begin
          op_a_nxt  = {rs_a_i, op_a[OPW-1:CHUNKSIZE]};
          op_b_nxt  = {rs_b_i, op_b[OPW-1:CHUNKSIZE]};
          sel_nxt   = sel_i;
          cnt_nxt   = CW'(1);
          state_nxt = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        op_a_nxt = {rs_a_i, op_a[OPW-1:CHUNKSIZE]};
        op_b_nxt = {rs_b_i, op_b[OPW-1:CHUNKSIZE]};
        cnt_nxt  = cnt + CW'(1);
        if (cnt == CNT_LAST_OP) begin
          state_nxt  = ST_WAIT;
          result_nxt = sel_q ? (full_a_c + full_b_c) : (full_a_c & full_b_c);
        end
      end
      ST_WAIT: begin
        cnt_nxt = cnt + CW'(1);
        if (cnt == CNT_WAIT_END) state_nxt = ST_RESPOND;
      end
      ST_RESPOND: begin
        if (cnt == CNT_LAST_RES) begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      default: state_nxt = ST_IDLE;
    endcase

    // Outputs are registered from the next-state view so they line up with state
    idx_c    = cnt_nxt - CNT_FIRST_RES;
    busy_nxt = (state_nxt != ST_IDLE);
    if (state_nxt == ST_RESPOND) begin
      for (int unsigned i = 0; i < NCHUNK; i++) begin
        if (idx_c == CW'(i)) res_nxt = result[i*CHUNKSIZE +: CHUNKSIZE];
      end
      resp_nxt = (cnt_nxt == CNT_LAST_RES);
    end
  end

endmodule

// File: tb/tb_ccx_emu_unit.sv
// Scoreboard bench for ccx_emu_unit: default configuration plus a CHUNKSIZE=2, RES_DLY=17 instance.
module tb_ccx_emu_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       req0, sel0, resp0, busy0, err0;
  logic [3:0] a0, b0, res0;
  logic       req1, sel1, resp1, busy1, err1;
  logic [1:0] a1, b1, res1;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [31:0] q0[$];
  logic [31:0] q1[$];
  logic [31:0] hist0 = '0;
  logic [31:0] hist1 = '0;
  logic [31:0] e0, e1;

  ccx_emu_unit #(.CHUNKSIZE(4), .RES_DLY(10)) dut0 (
    .clk_i(clk), .rst_i(rst), .req_i(req0), .sel_i(sel0),
    .rs_a_i(a0), .rs_b_i(b0), .res_o(res0), .resp_o(resp0),
    .busy_o(busy0), .err_o(err0)
  );

  ccx_emu_unit #(.CHUNKSIZE(2), .RES_DLY(17)) dut1 (
    .clk_i(clk), .rst_i(rst), .req_i(req1), .sel_i(sel1),
    .rs_a_i(a1), .rs_b_i(b1), .res_o(res1), .resp_o(resp1),
    .busy_o(busy1), .err_o(err1)
  );

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  // Monitors: assemble the streamed chunks and compare on each completion pulse
  always @(negedge clk) begin
    hist0 = {res0, hist0[31:4]};
    if (busy0 === 1'b0) begin
      checks++;
      if (res0 !== 4'h0) begin
        errors++;
        $display("FAIL res0_idle_zero: got %0h required 0", res0);
      end
    end
    if (resp0 === 1'b1) begin
      checks++;
      if (q0.size() == 0) begin
        errors++;
        $display("FAIL resp0_unexpected: got result %0h required no response", hist0);
      end else begin
        e0 = q0.pop_front();
        if (hist0 !== e0) begin
          errors++;
          $display("FAIL result0: got %0h required %0h", hist0, e0);
        end
      end
    end
  end

  always @(negedge clk) begin
    hist1 = {res1, hist1[31:2]};
    if (resp1 === 1'b1) begin
      checks++;
      if (q1.size() == 0) begin
        errors++;
        $display("FAIL resp1_unexpected: got result %0h required no response", hist1);
      end else begin
        e1 = q1.pop_front();
        if (hist1 !== e1) begin
          errors++;
          $display("FAIL result1: got %0h required %0h", hist1, e1);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic wait_to(input int t);
    while (cyc < t) tick();
  endtask

  // Issue one transaction on dut0; extra_k adds an illegal req, abort_k pulses reset mid-stream
  task automatic send0(input logic s, input logic [31:0] a, input logic [31:0] b,
                       input int extra_k, input int abort_k, input logic [31:0] expv,
                       output int t);
    t = cyc;
    if (abort_k < 0) q0.push_back(expv);
    for (int k = 0; k < 8; k++) begin
      req0 = (k == 0) || (k == extra_k);
      sel0 = (k == 0) ? s : 1'($urandom);
      a0   = a[k*4 +: 4];
      b0   = b[k*4 +: 4];
      if (k == abort_k) begin
        req0 = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("rst_res",  32'(res0),  32'd0);
        chk("rst_resp", 32'(resp0), 32'd0);
        chk("rst_busy", 32'(busy0), 32'd0);
        chk("rst_err",  32'(err0),  32'd0);
        #2 rst = 1'b0;
        tick();
        return;
      end
      if (k == extra_k) chk("err_pre", 32'(err0), 32'd0);
      tick();
      if (k == 0) chk("busy_t1", 32'(busy0), 32'd1);
      if (k == extra_k) chk("err_set", 32'(err0), 32'd1);
    end
    req0 = 1'b0;
    sel0 = 1'($urandom);
    a0   = 4'($urandom);
    b0   = 4'($urandom);
  endtask

  initial begin
    int t;
    logic [31:0] v;
    rst = 1'b0;
    req0 = 1'b0; sel0 = 1'b0; a0 = '0; b0 = '0;
    req1 = 1'b0; sel1 = 1'b0; a1 = '0; b1 = '0;
    #1 rst = 1'b1;
    #1;
    chk("reset_res0",  32'(res0),  32'd0);
    chk("reset_resp0", 32'(resp0), 32'd0);
    chk("reset_busy0", 32'(busy0), 32'd0);
    chk("reset_err0",  32'(err0),  32'd0);
    chk("reset_busy1", 32'(busy1), 32'd0);
    tick();
    tick();
    rst = 1'b0;
    cyc = 0;
    tick();

    // AND, then a back-to-back ADD in the first idle cycle
    send0(1'b0, 32'hF0F01234, 32'hFFFF00FF, -1, -1, 32'hF0F00034, t);
    chk("and_busy_t8", 32'(busy0), 32'd1);
    wait_to(t + 9);
    chk("and_res_t9", 32'(res0), 32'd0);
    wait_to(t + 10);
    chk("and_res_t10", 32'(res0), 32'h4);
    wait_to(t + 11);
    chk("and_res_t11", 32'(res0), 32'h3);
    wait_to(t + 16);
    chk("and_resp_t16", 32'(resp0), 32'd0);
    wait_to(t + 17);
    chk("and_resp_t17", 32'(resp0), 32'd1);
    chk("and_res_t17",  32'(res0),  32'hF);
    chk("and_busy_t17", 32'(busy0), 32'd1);
    wait_to(t + 18);
    chk("and_busy_t18", 32'(busy0), 32'd0);
    chk("and_res_t18",  32'(res0),  32'd0);
    send0(1'b1, 32'h00000005, 32'h00000007, -1, -1, 32'h0000000C, t);
    wait_to(t + 10);
    chk("b2b_res_t10", 32'(res0), 32'hC);
    chk("b2b_err",     32'(err0), 32'd0);
    wait_to(t + 18);

    // ADD wrap and carry into chunk 1
    send0(1'b1, 32'hFFFFFFFF, 32'h00000001, -1, -1, 32'h00000000, t);
    wait_to(t + 17);
    chk("wrap_resp_t17", 32'(resp0), 32'd1);
    wait_to(t + 20);
    send0(1'b1, 32'h0000000F, 32'h00000001, -1, -1, 32'h00000010, t);
    wait_to(t + 11);
    chk("carry_res_t11", 32'(res0), 32'h1);
    wait_to(t + 18);

    // Protocol errors: extra req during capture and in the resp cycle
    send0(1'b0, 32'h12345678, 32'h0F0F0F0F, 3, -1, 32'h02040608, t);
    wait_to(t + 17);
    chk("perr_resp_t17", 32'(resp0), 32'd1);
    req0 = 1'b1;
    sel0 = 1'b1;
    a0   = 4'($urandom);
    b0   = 4'($urandom);
    tick();
    req0 = 1'b0;
    chk("perr_err_t18",  32'(err0),  32'd1);
    chk("perr_busy_t18", 32'(busy0), 32'd0);
    repeat (20) tick();
    chk("perr_err_sticky", 32'(err0),  32'd1);
    chk("perr_no_second",  32'(busy0), 32'd0);

    // Asynchronous reset mid-transaction, then a clean AND
    send0(1'b0, 32'hFFFFFFFF, 32'h13579BDF, -1, 5, 32'h0, t);
    repeat (20) tick();
    chk("post_rst_busy", 32'(busy0), 32'd0);
    chk("post_rst_err",  32'(err0),  32'd0);
    send0(1'b0, 32'hDEADBEEF, 32'h00FF00FF, -1, -1, 32'h00AD00EF, t);
    wait_to(t + 10);
    chk("rst_and_res_t10", 32'(res0), 32'hF);
    wait_to(t + 18);

    // Narrow-chunk, long-latency instance
    v = 32'hA5A5A5A5;
    t = cyc;
    q1.push_back(32'hA5A5A5A5);
    for (int k = 0; k < 16; k++) begin
      req1 = (k == 0);
      sel1 = 1'b0;
      a1   = v[k*2 +: 2];
      b1   = v[k*2 +: 2];
      tick();
    end
    req1 = 1'b0;
    a1 = '0;
    b1 = '0;
    wait_to(t + 16);
    chk("p2_res_t16", 32'(res1), 32'd0);
    wait_to(t + 17);
    chk("p2_res_t17", 32'(res1), 32'd1);
    wait_to(t + 19);
    chk("p2_res_t19", 32'(res1), 32'd2);
    wait_to(t + 31);
    chk("p2_resp_t31", 32'(resp1), 32'd0);
    wait_to(t + 32);
    chk("p2_resp_t32", 32'(resp1), 32'd1);
    chk("p2_res_t32",  32'(res1),  32'd2);
    wait_to(t + 33);
    chk("p2_busy_t33", 32'(busy1), 32'd0);
    chk("p2_err",      32'(err1),  32'd0);

    tick();
    chk("q0_drained", 32'(q0.size()), 32'd0);
    chk("q1_drained", 32'(q1.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ccx_emu_unit.md
# ccx_emu_unit

Emulation-only responder for the FazyRV ExoTiny custom-instruction (CCX) port on the ECP5 board. It sits downstream of the core's CCX outputs: it deserialises the two operands streamed chunk-serially by the core and computes a selectable 32-bit operation. It then streams the result back chunk-serially at a fixed, parameterised latency, with a completion pulse. This replaces the free-running delay-line model with a transaction-based unit that has real operand capture, busy tracking and protocol-error detection.

## Interface
- CHUNKSIZE, 4, bits per transferred chunk; legal values 1, 2, 4, 8; NCHUNK = 32/CHUNKSIZE.
- RES_DLY, 10, cycles from the request cycle to the first result chunk; must be ≥ NCHUNK+1.
- clk_i  in  1  system clock; all logic on its rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- req_i  in  1  single-cycle pulse marking operand chunk 0.
- sel_i  in  1  operation select, sampled only in the req_i cycle: 0 = AND, 1 = ADD mod 2^32.
- rs_a_i  in  CHUNKSIZE  operand A chunk.
- rs_b_i  in  CHUNKSIZE  operand B chunk.
- res_o  out  CHUNKSIZE  result chunk; registered.
- resp_o  out  1  completion pulse; registered.
- busy_o  out  1  high whenever a transaction is in progress.
- err_o  out  1  sticky protocol-error flag.

## Operation
- Chunk order is LSB first: chunk k carries bits [k*CHUNKSIZE +: CHUNKSIZE].
- States are IDLE, CAPTURE, WAIT and RESPOND. A cycle counter cnt is ≥ ceil(log2(RES_DLY+NCHUNK)) bits wide.
- IDLE:
  - An edge with req_i=1 stores chunk 0 of A and B and latches sel.
  - It sets cnt=1 and moves to CAPTURE.
- CAPTURE:
  - Each edge stores chunk cnt of A and B into the operand shift registers and increments cnt.
  - After chunk NCHUNK-1 is stored, the state moves to WAIT.
  - The 32-bit result is computed once from the full operands and held in a result register. AND is bitwise; ADD wraps mod 2^32 and the carry-out is discarded.
- WAIT: cnt counts until the first result chunk is due, then the state moves to RESPOND.
- RESPOND:
  - Drives result chunks 0..NCHUNK-1 on consecutive cycles.
  - resp_o is high only with the last chunk.
  - The unit returns to IDLE on the following edge.
- res_o = 0 in every cycle outside the result window.
- busy_o = (state != IDLE).
- req_i=1 in any cycle where state != IDLE:
  - The request is ignored and the operands and sel on those cycles are not sampled.
  - err_o is set to 1 and the in-flight transaction completes unaffected.
  - err_o clears only on rst_i.
- rs_a_i, rs_b_i and sel_i are don't-care outside their defined sample cycles.

## Timing
- Take the req_i cycle as T. Operand chunk k is sampled at the edge ending cycle T+k, for k = 0..NCHUNK-1.
- busy_o is high from T+1 through T+RES_DLY+NCHUNK-1 inclusive.
- res_o carries result chunk k during cycle T+RES_DLY+k.
- resp_o is high for exactly cycle T+RES_DLY+NCHUNK-1.
- With defaults (NCHUNK=8, RES_DLY=10): result occupies T+10..T+17 and resp_o is high at T+17.
- Back-to-back transactions:
  - A req_i at T+RES_DLY+NCHUNK is accepted, because the unit is back in IDLE.
  - A req_i at T+RES_DLY+NCHUNK-1 (the resp_o cycle) is an error.
- Reset:
  - rst_i asserted at any time forces state=IDLE, cnt=0, operands/result=0, res_o=0, resp_o=0, busy_o=0 and err_o=0 immediately, without waiting for a clock edge.
  - The first edge after deassertion may accept req_i.
- Reset mid-transaction produces no resp_o and no partial result.

## Test plan
- AND:
  - Stimulus: req at T with sel=0, A=0xF0F01234, B=0xFFFF00FF.
  - Expected: res_o = 4,3,0,0,0,F,0,F on T+10..T+17, resp_o only at T+17, busy_o high T+1..T+17.
- ADD wrap:
  - Stimulus: sel=1, A=0xFFFFFFFF, B=0x00000001.
  - Expected: all eight chunks = 0 and resp_o at T+17.
  - Follow-up: A=0x0000000F, B=0x00000001 gives chunks 0,1,0,0,0,0,0,0.
- Back-to-back:
  - Stimulus: second req (sel=1, A=5, B=7) at T+18.
  - Expected: accepted, chunk 0 = C at T+28, err_o stays 0.
- Protocol error:
  - Stimulus: extra req at T+3 and a second extra at T+17.
  - Expected: first result unchanged, err_o=1 from T+4 onward and stays high, no second transaction.
- Async reset:
  - Stimulus: rst_i pulsed mid-edge-free at T+5.
  - Expected: all outputs 0 immediately, no resp_o in the following 20 cycles.
  - Follow-up: a new AND transaction after release is correct.
- Parameter variant:
  - Configuration: CHUNKSIZE=2, RES_DLY=17.
  - Stimulus: AND, A=B=0xA5A5A5A5.
  - Expected: 16 chunks 1,1,2,2,… on T+17..T+32, resp_o at T+32.
